multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore state-machine controller that sequences the shared multicycle MIPS datapath: one ALU, one unified instruction/data memory port and the instruction register (IR). It replaces the single-cycle decoder for the multicycle core. It walks each instruction through fetch, decode, execute, memory and writeback states. It drives every mux select and write strobe and computes the PC enable from the ALU zero flag.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `op`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0]; valid from DECODE onward.
- `zero`  in  1  ALU zero flag for the current cycle.
- `mem_ready`  in  1  memory access completes this cycle (see Configuration).
- `pcen`  out  1  PC register enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  IR load enable.
- `regdst`  out  1  destination register: 0 = rt, 1 = rd.
- `memtoreg`  out  1  writeback data: 0 = ALUOut, 1 = memory data.
- `regwrite`  out  1  register file write enable.
- `alusrca`  out  1  ALU A: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pcsrc`  out  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `illegal`  out  1  one-cycle pulse on an unsupported op or funct.
- `state_o`  out  4  current state encoding, for debug.

## Operation

State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH→DECODE.
- DECODE dispatches on `op`:
  - lw (100011) and sw (101011) → MEMADR.
  - R-type (000000) → EXECUTE.
  - beq (000100) and bne (000101) → BRANCH.
  - addi (001000) → ADDIEX.
  - j (000010) → JUMP.
  - Any other `op` → FETCH, with `illegal` and `instr_done` pulsed in DECODE.
- MEMADR → MEMRD for lw, MEMWR for sw.
- MEMRD→MEMWB, EXECUTE→ALUWB, ADDIEX→ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP → FETCH, with `instr_done`=1 in that state.

Outputs are decoded from state only (Moore), except `pcen`. Any output not listed for a state is 0; `alucontrol` defaults to 010.
- FETCH: alusrcb=01, irwrite=1, pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, alucontrol from `funct`.
  - add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111.
  - Any other `funct` → 010 and `illegal` pulsed; the instruction still completes (ALUWB writes the sum).
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, alucontrol=110, pcsrc=01.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.

PC enable: `pcen` = pcwrite | (BRANCH & beq & zero) | (BRANCH & bne & ~zero).

## Timing

- Reset: while `reset`=1 at an edge, state ← FETCH.
- While `reset` is high, `pcen`, `irwrite`, `memwrite`, `regwrite`, `instr_done` and `illegal` are forced to 0. All other outputs show their FETCH values (alusrcb=01, alucontrol=010, rest 0).
- Reset mid-instruction abandons it: no write strobe fires, and FETCH begins the cycle after `reset` deasserts.
- Latency with `mem_ready` held at 1:
  - lw 5 cycles.
  - sw, R-type and addi 4 cycles.
  - beq, bne and j 3 cycles.
- `instr_done` is high for exactly one cycle per instruction; back-to-back instructions have no idle cycle between them.

## Configuration

`MULTICYCLE_MEM_WAIT_EN`:
- Defined:
  - FETCH, MEMRD and MEMWR hold their state while `mem_ready`=0.
  - In FETCH, `irwrite` and `pcen` assert only in the cycle where `mem_ready`=1.
  - In MEMWR, `memwrite` stays high for the whole wait; `instr_done` asserts only when `mem_ready`=1.
  - `iord` is stable for the entire wait.
- Undefined: `mem_ready` is ignored and each of those states lasts exactly one cycle.

## Test plan

- Reset held 3 cycles, then released with IR = add $3,$1,$2 (op 0, funct 100000). Required: `state_o` goes 0,1,6,7,0; `alucontrol`=010 in EXECUTE; `regwrite`=1 and `regdst`=1 only in ALUWB; `instr_done` high in ALUWB.
- lw. Required: state sequence 0,1,2,3,4; `iord`=1 in MEMRD; `memtoreg`=1 and `regwrite`=1 in MEMWB.
- sw. Required: sequence 0,1,2,5; `memwrite`=1 for exactly one cycle; `regwrite` never asserted.
- beq with `zero`=1 → `pcen`=1 in BRANCH. beq with `zero`=0 → `pcen`=0. bne with `zero`=0 → `pcen`=1. bne with `zero`=1 → `pcen`=0.
- op=111111 → `illegal` and `instr_done` pulse in DECODE, then FETCH next cycle. R-type with funct 000000 → `illegal` pulse in EXECUTE, `alucontrol`=010, ALUWB still writes.
- With `MULTICYCLE_MEM_WAIT_EN` defined, run sw with `mem_ready`=0 for 3 cycles in MEMWR. Required: `memwrite`=1 for 4 cycles; `instr_done` only on the 4th. Assert `reset` during MEMWR: `memwrite` drops in the reset cycle and state returns to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore controller sequencing the shared multicycle MIPS datapath.
// Define MULTICYCLE_MEM_WAIT_EN to let FETCH/MEMRD/MEMWR stall on mem_ready.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
        MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
        BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                           OP_ADDI = 6'b001000, OP_J = 6'b000010;
    state_t state, next, cur;
    logic ready, pcwrite, op_ok, funct_ok;
    logic [2:0] funct_alu;
`ifdef MULTICYCLE_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = mem_ready | 1'b1;
`endif
    assign op_ok = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    assign funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    assign funct_alu = funct == 6'b100010 ? 3'b110 :
                       funct == 6'b100100 ? 3'b000 :
                       funct == 6'b100101 ? 3'b001 :
                       funct == 6'b101010 ? 3'b111 : 3'b010;
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:   next = ready ? DECODE : FETCH;
            DECODE:  next = (op == OP_LW || op == OP_SW) ? MEMADR :
                            op == OP_R ? EXECUTE :
                            (op == OP_BEQ || op == OP_BNE) ? BRANCH :
                            op == OP_ADDI ? ADDIEX :
                            op == OP_J ? JUMP : FETCH;
            MEMADR:  next = op == OP_SW ? MEMWR : MEMRD;
            MEMRD:   next = ready ? MEMWB : MEMRD;
            MEMWR:   next = ready ? FETCH : MEMWR;
            EXECUTE: next = ALUWB;
            ADDIEX:  next = ADDIWB;
            default: next = FETCH;
        endcase
    end
    always_ff @(posedge clk) state <= reset ? FETCH : next;
    // Reset shows FETCH decode with every strobe suppressed, even before the first edge.
    assign cur = reset ? FETCH : state;
    assign state_o = cur;
    always_comb begin
        iord = 1'b0;
        memwrite = 1'b0;
        irwrite = 1'b0;
        regdst = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        pcsrc = 2'b00;
        alucontrol = 3'b010;
        instr_done = 1'b0;
        illegal = 1'b0;
        pcwrite = 1'b0;
        case (cur)
            FETCH:   begin alusrcb = 2'b01; irwrite = ready; pcwrite = ready; end
            DECODE:  begin alusrcb = 2'b11; illegal = ~op_ok; instr_done = ~op_ok; end
            MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            MEMRD:   iord = 1'b1;
            MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; instr_done = 1'b1; end
            MEMWR:   begin iord = 1'b1; memwrite = 1'b1; instr_done = ready; end
            EXECUTE: begin alusrca = 1'b1; alucontrol = funct_alu; illegal = ~funct_ok; end
            ALUWB:   begin regdst = 1'b1; regwrite = 1'b1; instr_done = 1'b1; end
            BRANCH:  begin alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01; instr_done = 1'b1; end
            ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            ADDIWB:  begin regwrite = 1'b1; instr_done = 1'b1; end
            JUMP:    begin pcsrc = 2'b10; pcwrite = 1'b1; instr_done = 1'b1; end
            default: ;
        endcase
        pcen = pcwrite | (cur == BRANCH && ((op == OP_BEQ && zero) || (op == OP_BNE && !zero)));
        if (reset) {pcen, irwrite, memwrite, regwrite, instr_done, illegal} = '0;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed literal checks plus randomized run against an instruction-level model.
module tb_multicycle_ctrl;
    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [5:0] op = 6'd0, funct = 6'b100000;
    logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, instr_done, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;
`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif
    localparam logic [5:0] FC [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    localparam logic [2:0] AC [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    localparam logic [5:0] OPS [8] = '{6'd0, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .instr_done(instr_done), .illegal(illegal),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Bit layout: pcen[20] iord[19] memwrite[18] irwrite[17] regdst[16] memtoreg[15]
    // regwrite[14] alusrca[13] alusrcb[12:11] pcsrc[10:9] alucontrol[8:6] done[5] illegal[4] state[3:0]
    wire [20:0] dutv = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                        alusrcb, pcsrc, alucontrol, instr_done, illegal, state_o};

    int n_cmp = 0, n_err = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] expv(input int st_in, input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic r, input logic rs);
        logic pw, ior, mw, irw, rd, mtr, rw, asa, done, ill, pe;
        logic [1:0] asb, ps;
        logic [2:0] alu;
        int st;
        {pw, ior, mw, irw, rd, mtr, rw, asa, done, ill} = '0;
        asb = 2'b00;
        ps = 2'b00;
        alu = 3'b010;
        st = rs ? 0 : st_in;
        case (st)
            0: begin asb = 2'b01; irw = r; pw = r; end
            1: begin asb = 2'b11; ill = !(o inside {OPS[0], OPS[1], OPS[2], OPS[3], OPS[4], OPS[5], OPS[6]}); done = ill; end
            2: begin asa = 1'b1; asb = 2'b10; end
            3: ior = 1'b1;
            4: begin mtr = 1'b1; rw = 1'b1; done = 1'b1; end
            5: begin ior = 1'b1; mw = 1'b1; done = r; end
            6: begin
                asa = 1'b1;
                ill = 1'b1;
                for (int i = 0; i < 5; i++) if (f == FC[i]) begin alu = AC[i]; ill = 1'b0; end
            end
            7: begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
            8: begin asa = 1'b1; alu = 3'b110; ps = 2'b01; done = 1'b1; end
            9: begin asa = 1'b1; asb = 2'b10; end
            10: begin rw = 1'b1; done = 1'b1; end
            11: begin ps = 2'b10; pw = 1'b1; done = 1'b1; end
            default: ;
        endcase
        pe = pw | (st == 8 && ((o == 6'b000100 && z) || (o == 6'b000101 && !z)));
        if (rs) {pe, irw, mw, rw, done, ill} = '0;
        return {pe, ior, mw, irw, rd, mtr, rw, asa, asb, ps, alu, done, ill, st[3:0]};
    endfunction

    // Instruction-level model: each instruction is a list of states walked one per cycle.
    int seq[5] = '{0, 0, 0, 0, 0};
    int idx = 0, len = 1;
    always @(negedge clk) begin
        logic r;
        r = WAIT ? mem_ready : 1'b1;
        if (idx == 0) begin
            case (op)
                6'b100011: begin seq = '{0, 1, 2, 3, 4}; len = 5; end
                6'b101011: begin seq = '{0, 1, 2, 5, 0}; len = 4; end
                6'b000000: begin seq = '{0, 1, 6, 7, 0}; len = 4; end
                6'b000100, 6'b000101: begin seq = '{0, 1, 8, 0, 0}; len = 3; end
                6'b001000: begin seq = '{0, 1, 9, 10, 0}; len = 4; end
                6'b000010: begin seq = '{0, 1, 11, 0, 0}; len = 3; end
                default: begin seq = '{0, 1, 0, 0, 0}; len = 2; end
            endcase
        end
        check("cycle", {11'd0, dutv}, {11'd0, expv(seq[idx], op, funct, zero, r, reset)});
        if (reset) idx = 0;
        else if (!(seq[idx] inside {0, 3, 5} && !r)) idx = (idx + 1 == len) ? 0 : idx + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [20:0] hist[8];
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
        op = o;
        funct = f;
        zero = z;
        #1;
        for (int k = 0; k < n; k++) begin
            hist[k] = dutv;
            step();
            #2;
        end
    endtask

    localparam int ADD_ST [5] = '{0, 1, 6, 7, 0};
    localparam int ADD_WB [5] = '{0, 0, 0, 1, 0};
    localparam int LW_ST [5] = '{0, 1, 2, 3, 4};
    localparam int SW_ST [4] = '{0, 1, 2, 5};

    initial begin
        int cnt, dmask;
        repeat (3) begin
            step();
            #2;
            check("rst_state", state_o, 0);
            check("rst_strobes", {pcen, irwrite, memwrite, regwrite, instr_done, illegal}, 0);
            check("rst_alusrcb", alusrcb, 1);
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin step(); #2; end
            check("add_state", state_o, ADD_ST[k]);
            check("add_regwrite", regwrite, ADD_WB[k]);
            check("add_regdst", regdst, ADD_WB[k]);
            check("add_done", instr_done, ADD_WB[k]);
            check("add_alu", alucontrol, 3'b010);
        end
        run(6'b100011, 6'd0, 1'b0, 5);
        for (int k = 0; k < 5; k++) check("lw_state", hist[k][3:0], LW_ST[k]);
        check("lw_iord", hist[3][19], 1);
        check("lw_memwb", {hist[4][15], hist[4][14]}, 2'b11);
        run(6'b101011, 6'd0, 1'b0, 4);
        cnt = 0;
        dmask = 0;
        for (int k = 0; k < 4; k++) begin
            check("sw_state", hist[k][3:0], SW_ST[k]);
            cnt += int'(hist[k][18]);
            dmask += int'(hist[k][14]);
        end
        check("sw_memwrite_cycles", cnt, 1);
        check("sw_regwrite_cycles", dmask, 0);
        run(6'b000100, 6'd0, 1'b1, 3);
        check("beq_z1_pcen", hist[2][20], 1);
        run(6'b000100, 6'd0, 1'b0, 3);
        check("beq_z0_pcen", hist[2][20], 0);
        run(6'b000101, 6'd0, 1'b0, 3);
        check("bne_z0_pcen", hist[2][20], 1);
        run(6'b000101, 6'd0, 1'b1, 3);
        check("bne_z1_pcen", hist[2][20], 0);
        run(6'b111111, 6'd0, 1'b0, 2);
        check("badop_ill_done", {hist[1][4], hist[1][5]}, 2'b11);
        check("badop_next_fetch", state_o, 0);
        run(6'b000000, 6'b000000, 1'b0, 4);
        check("badfn_ill", hist[2][4], 1);
        check("badfn_alu", hist[2][8:6], 3'b010);
        check("badfn_wb", {hist[3][3:0], hist[3][14]}, {4'd7, 1'b1});
`ifdef MULTICYCLE_MEM_WAIT_EN
        op = 6'b101011;
        repeat (3) begin step(); #2; end
        mem_ready = 1'b0;
        cnt = 0;
        dmask = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            #1;
            cnt += int'(memwrite);
            dmask |= int'(instr_done) << k;
            step();
            #2;
        end
        check("wait_memwrite_cycles", cnt, 4);
        check("wait_done_mask", dmask, 4'b1000);
        repeat (3) begin step(); #2; end
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("wait_rst_memwrite", memwrite, 0);
        step();
        reset = 1'b0;
        #1;
        check("wait_rst_state", state_o, 0);
        mem_ready = 1'b1;
`endif
        repeat (4000) begin
            step();
            if (idx == 0) begin
                op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 7)];
                funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : FC[$urandom_range(0, 4)];
            end
            zero = 1'($urandom);
            mem_ready = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 60) == 0;
        end
        reset = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
